// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the down_timer block and its prescaler.
package down_timer_pkg;

    // Default widths for the count/load value and the prescaler compare value.
    localparam int unsigned DEF_BW          = 8;
    localparam int unsigned DEF_PRESCALE_BW = 4;

    // Timer control states; any unlisted encoding decodes back to ST_IDLE.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } timer_state_e;

endpackage : down_timer_pkg

// File: rtl/down_timer_prescaler.sv
// Clear-on-start, wrap-on-compare tick generator.
// The tick fires on a cycle where the counter equals cmp_i. The counter then wraps to 0,
// so a tick occurs every cmp_i+1 enabled cycles.
module prescaler #(
    parameter int unsigned PRESCALE_BW = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic [PRESCALE_BW-1:0] cmp_i,
    output logic                   tick_o
);

    logic [PRESCALE_BW-1:0] r_cnt;

    // Compare is made against the live cmp_i, so a new compare value applies at the next compare.
    assign tick_o = en_i && !clr_i && (r_cnt == cmp_i);

    // Prescale counter: cleared while idle, wraps on tick.
    // It wraps naturally mod 2^PRESCALE_BW if cmp_i is lowered below the current count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (clr_i) begin
            r_cnt <= '0;
        end else if (en_i) begin
            if (tick_o) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + PRESCALE_BW'(1);
            end
        end
    end

endmodule : prescaler

// File: rtl/down_timer.sv
// Loadable down-counting timer with prescaler, one-cycle done pulse and optional auto-reload.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int unsigned BW          = DEF_BW,
    parameter int unsigned PRESCALE_BW = DEF_PRESCALE_BW
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [BW-1:0]          load_val_i,
    input  logic [PRESCALE_BW-1:0] prescale_i,
    input  logic                   start_i,
    input  logic                   stop_i,
    input  logic                   reload_i,
    output logic [BW-1:0]          count_o,
    output logic                   busy_o,
    output logic                   done_o
);

    timer_state_e  r_state;
    timer_state_e  w_state_nxt;
    logic [BW-1:0] r_count;
    logic [BW-1:0] w_count_nxt;
    logic          r_busy;
    logic          w_busy_nxt;
    logic          r_done;
    logic          w_done_nxt;
    logic          w_pre_clr;
    logic          w_pre_en;
    logic          w_tick;

    // The prescaler counts only in RUN and is held cleared in IDLE,
    // so every accepted start begins from a zero prescale phase.
    assign w_pre_en  = (r_state == ST_RUN);
    assign w_pre_clr = (r_state != ST_RUN);

    prescaler #(
        .PRESCALE_BW (PRESCALE_BW)
    ) u_prescaler (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (w_pre_clr),
        .en_i   (w_pre_en),
        .cmp_i  (prescale_i),
        .tick_o (w_tick)
    );

    // State, count and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state and next-output decode.
    // Stop has priority over both start and expiry.
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy_nxt = 1'b0;
                if (start_i && !stop_i) begin
                    if (load_val_i != '0) begin
                        w_count_nxt = load_val_i;
                        w_busy_nxt  = 1'b1;
                        w_state_nxt = ST_RUN;
                    end else begin
                        // A zero-length start expires immediately without entering RUN.
                        w_count_nxt = '0;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_state_nxt = ST_IDLE;
                    w_busy_nxt  = 1'b0;
                end else if (w_tick) begin
                    if (r_count > BW'(1)) begin
                        w_count_nxt = r_count - BW'(1);
                    end else begin
                        // Expiry: a count of 0 is never held in RUN, so this branch means count==1.
                        w_done_nxt = 1'b1;
                        if (reload_i && (load_val_i != '0)) begin
                            w_count_nxt = load_val_i;
                        end else begin
                            w_count_nxt = '0;
                            w_busy_nxt  = 1'b0;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign count_o = r_count;
    assign busy_o  = r_busy;
    assign done_o  = r_done;

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed self-checking bench for down_timer (BW=8, PRESCALE_BW=4).
module tb_down_timer;

    logic       clk;
    logic       rst;
    logic [7:0] load_val;
    logic [3:0] prescale;
    logic       start;
    logic       stop;
    logic       reload;
    logic [7:0] count;
    logic       busy;
    logic       done;

    int n_tests = 0;
    int n_fail  = 0;

    down_timer #(
        .BW          (8),
        .PRESCALE_BW (4)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_val_i (load_val),
        .prescale_i (prescale),
        .start_i    (start),
        .stop_i     (stop),
        .reload_i   (reload),
        .count_o    (count),
        .busy_o     (busy),
        .done_o     (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [7:0] c, input logic b, input logic d);
        check({tag, ".count"}, 32'(count), 32'(c));
        check({tag, ".busy"},  32'(busy),  32'(b));
        check({tag, ".done"},  32'(done),  32'(d));
    endtask

    // Advance one rising edge, then settle 1 time unit so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst      = 1'b1;
        load_val = '0;
        prescale = '0;
        start    = 1'b0;
        stop     = 1'b0;
        reload   = 1'b0;
        tick();
        tick();
        chk3("reset", 8'd0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();
        chk3("idle_after_reset", 8'd0, 1'b0, 1'b0);

        // L=3, P=0: one-cycle start
        load_val = 8'd3; prescale = 4'd0; start = 1'b1;
        tick();
        chk3("l3_e0", 8'd3, 1'b1, 1'b0);
        start = 1'b0;
        tick(); chk3("l3_e1", 8'd2, 1'b1, 1'b0);
        tick(); chk3("l3_e2", 8'd1, 1'b1, 1'b0);
        tick(); chk3("l3_e3", 8'd0, 1'b0, 1'b1);
        tick(); chk3("l3_e4", 8'd0, 1'b0, 1'b0);

        // L=2, P=3: decrement every 4 cycles, done after 8
        load_val = 8'd2; prescale = 4'd3; start = 1'b1;
        tick(); chk3("l2p3_e0", 8'd2, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            if (i < 4)       chk3("l2p3_run", 8'd2, 1'b1, 1'b0);
            else if (i < 8)  chk3("l2p3_run", 8'd1, 1'b1, 1'b0);
            else             chk3("l2p3_exp", 8'd0, 1'b0, 1'b1);
        end
        tick(); chk3("l2p3_after", 8'd0, 1'b0, 1'b0);

        // L=4, P=1, reload: done every 8 cycles, count returns to 4, never 0
        load_val = 8'd4; prescale = 4'd1; reload = 1'b1; start = 1'b1;
        tick(); chk3("rl_e0", 8'd4, 1'b1, 1'b0);
        start = 1'b0;
        for (int p = 0; p < 3; p++) begin
            if (p == 2) reload = 1'b0;
            for (int i = 1; i <= 8; i++) begin
                tick();
                if (i < 8)       chk3("rl_run", 8'(4 - i / 2), 1'b1, 1'b0);
                else if (p < 2)  chk3("rl_reload", 8'd4, 1'b1, 1'b1);
                else             chk3("rl_final", 8'd0, 1'b0, 1'b1);
            end
        end
        tick(); chk3("rl_after", 8'd0, 1'b0, 1'b0);

        // L=10, P=0, stop at count 6
        load_val = 8'd10; prescale = 4'd0; start = 1'b1;
        tick(); chk3("stop_e0", 8'd10, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick(); chk3("stop_run", 8'(10 - i), 1'b1, 1'b0);
        end
        stop = 1'b1;
        tick(); chk3("stop_hit", 8'd6, 1'b0, 1'b0);
        stop = 1'b0;
        tick(); chk3("stop_hold", 8'd6, 1'b0, 1'b0);

        // start with L=0: single done pulse, stays IDLE
        load_val = 8'd0; start = 1'b1;
        tick(); chk3("l0_start", 8'd0, 1'b0, 1'b1);
        start = 1'b0;
        tick(); chk3("l0_after", 8'd0, 1'b0, 1'b0);

        // start & stop together in IDLE: stop wins
        load_val = 8'd5; start = 1'b1; stop = 1'b1;
        tick(); chk3("ss_idle", 8'd0, 1'b0, 1'b0);
        start = 1'b0; stop = 1'b0;

        // stop on the expiry cycle: no done, count holds 1
        load_val = 8'd2; start = 1'b1;
        tick(); chk3("sexp_e0", 8'd2, 1'b1, 1'b0);
        start = 1'b0;
        tick(); chk3("sexp_e1", 8'd1, 1'b1, 1'b0);
        stop = 1'b1;
        tick(); chk3("sexp_stop", 8'd1, 1'b0, 1'b0);
        stop = 1'b0;
        tick(); chk3("sexp_after", 8'd1, 1'b0, 1'b0);

        // start held through RUN is ignored; load change mid-run not resampled; restart from IDLE
        load_val = 8'd3; start = 1'b1;
        tick(); chk3("hold_e0", 8'd3, 1'b1, 1'b0);
        load_val = 8'd7;
        tick(); chk3("hold_e1", 8'd2, 1'b1, 1'b0);
        tick(); chk3("hold_e2", 8'd1, 1'b1, 1'b0);
        tick(); chk3("hold_e3", 8'd0, 1'b0, 1'b1);
        tick(); chk3("hold_restart", 8'd7, 1'b1, 1'b0);
        start = 1'b0; stop = 1'b1;
        tick(); chk3("hold_abort", 8'd7, 1'b0, 1'b0);
        stop = 1'b0;

        // reload with L=1, P=0: done every cycle, then drop reload
        load_val = 8'd1; reload = 1'b1; start = 1'b1;
        tick(); chk3("r1_e0", 8'd1, 1'b1, 1'b0);
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk3("r1_pulse", 8'd1, 1'b1, 1'b1);
        end
        reload = 1'b0;
        tick(); chk3("r1_last", 8'd0, 1'b0, 1'b1);
        tick(); chk3("r1_after", 8'd0, 1'b0, 1'b0);

        // reset asserted mid-RUN: L=200, P=0, after 10 cycles
        load_val = 8'd200; start = 1'b1;
        tick(); chk3("rst_e0", 8'd200, 1'b1, 1'b0);
        start = 1'b0;
        repeat (10) tick();
        chk3("rst_run", 8'd190, 1'b1, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk3("rst_async", 8'd0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        tick(); chk3("rst_release", 8'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_down_timer
